// File: rtl/paint_pkg.sv
// Shared types and defaults for the paint pixel writer slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package paint_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int FB_ADDR_W   = 19;
    localparam int COLOR_W_DEF = 4;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    // Point layout at the default colour width; the writer declares the same
    // layout with its own COLOR_W.
    typedef struct packed {
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic [COLOR_W_DEF-1:0] color;
    } point_t;

endpackage

// File: rtl/paint_point_fifo.sv
// Synchronous point FIFO with registered read data.
// Latency: pushed entry visible on empty the next cycle; rd_data updates on the edge that pops.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module paint_point_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign do_push = push && (!full || do_pop);

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/paint_pixel_writer.sv
// Buffers line-drawer points and turns them into framebuffer writes at y*H_RES + x.
// Latency: point pushed at edge t gives wr_req=1 from t+4; at least 6 cycles per single-pixel point.
// Backpressure: wr_req/wr_addr/wr_data hold until wr_ack; a push into a full FIFO is dropped and sets sticky overflow.
// Build option: PAINT_BRUSH_3X3_EN expands every point into a clipped 3x3 square.
module paint_pixel_writer
    import paint_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int COLOR_W    = COLOR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [X_W-1:0]       pix_x,
    input  logic [Y_W-1:0]       pix_y,
    input  logic [COLOR_W-1:0]   pen_color,
    output logic                 wr_req,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [COLOR_W-1:0]   wr_data,
    input  logic                 wr_ack,
    output logic                 busy,
    output logic                 overflow
);

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pt_t;

    localparam int XL_W = X_W + 1;
    localparam int YL_W = Y_W + 1;
    // Coordinates below are biased by +1 so a -1 offset never goes negative.
    localparam logic [X_W:0]           X_LIM = XL_W'(H_RES);
    localparam logic [Y_W:0]           Y_LIM = YL_W'(V_RES);
    localparam logic [FB_ADDR_W-1:0]   PITCH = FB_ADDR_W'(H_RES);

    state_t         state_q;
    state_t         state_d;
    pt_t            push_pt;
    pt_t            cur_pt;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [1:0]     dx_idx;
    logic [1:0]     dy_idx;
    logic           last_offset;
    logic [X_W:0]   sx;
    logic [Y_W:0]   sy;
    logic           on_screen;
    logic [X_W-1:0] tgt_x;
    logic [Y_W-1:0] tgt_y;

    assign push_pt = '{x: pix_x, y: pix_y, color: pen_color};

    // The FIFO's registered read data doubles as the working point register.
    paint_point_fifo #(
        .WIDTH ($bits(pt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pix_valid),
        .pop     (fifo_pop),
        .wr_data (push_pt),
        .rd_data (cur_pt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef PAINT_BRUSH_3X3_EN
    // Walk offsets dy outer, dx inner, starting top-left for each popped point.
    always_ff @(posedge clk) begin
        if (reset) begin
            dx_idx <= 2'd0;
            dy_idx <= 2'd0;
        end else if (fifo_pop) begin
            dx_idx <= 2'd0;
            dy_idx <= 2'd0;
        end else if (state_q == ST_NEXT && !last_offset) begin
            if (dx_idx == 2'd2) begin
                dx_idx <= 2'd0;
                dy_idx <= dy_idx + 2'd1;
            end else begin
                dx_idx <= dx_idx + 2'd1;
            end
        end
    end

    assign last_offset = (dx_idx == 2'd2) && (dy_idx == 2'd2);
`else
    assign dx_idx      = 2'd1;
    assign dy_idx      = 2'd1;
    assign last_offset = 1'b1;
`endif

    // Offset index 1 means zero offset, so sx/sy hold target+1.
    assign sx        = {1'b0, cur_pt.x} + {{(X_W-1){1'b0}}, dx_idx};
    assign sy        = {1'b0, cur_pt.y} + {{(Y_W-1){1'b0}}, dy_idx};
    assign on_screen = (sx != '0) && (sx <= X_LIM) && (sy != '0) && (sy <= Y_LIM);

    assign busy = !fifo_empty || (state_q != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = on_screen ? ST_ADDR : ST_NEXT;
            ST_ADDR:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (wr_req && wr_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT:  state_d = last_offset ? ST_IDLE : ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Target capture, address generation and the write request handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            tgt_x   <= '0;
            tgt_y   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    tgt_x <= X_W'(sx) - X_W'(1);
                    tgt_y <= Y_W'(sy) - Y_W'(1);
                end
                ST_ADDR: begin
                    wr_addr <= FB_ADDR_W'(tgt_y) * PITCH + FB_ADDR_W'(tgt_x);
                    wr_data <= cur_pt.color;
                end
                ST_WRITE: begin
                    if (!wr_req) begin
                        wr_req <= 1'b1;
                    end else if (wr_ack) begin
                        wr_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for a point lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (pix_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_paint_pixel_writer.sv
module tb_paint_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [3:0]  pen_color;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int passed = 0;
    int cycle = 0;
    int req_total = 0;
    int wa_q[$];
    int wd_q[$];
    int wc_q[$];

    paint_pixel_writer dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pen_color (pen_color),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Log every accepted write and every cycle spent requesting.
    always @(negedge clk) begin
        if (wr_req === 1'b1) req_total <= req_total + 1;
        if (wr_req === 1'b1 && wr_ack === 1'b1) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(int'(wr_data));
            wc_q.push_back(cycle);
        end
    end

    function automatic int addr_at(input int i);
        return (i < wa_q.size()) ? wa_q[i] : -1;
    endfunction

    function automatic int data_at(input int i);
        return (i < wd_q.size()) ? wd_q[i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < wc_q.size()) ? wc_q[i] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_point(input int x, input int y, input int c);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pen_color = 4'(c);
        step(1);
        pix_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (wr_req !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pen_color = '0; wr_ack = 1'b0;
        step(2);
        checks++; if (wr_req !== 1'b0) $display("FAIL reset_wr_req: got %b expected 0", wr_req); else passed++;
        checks++; if (wr_addr !== 19'd0) $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); else passed++;
        checks++; if (wr_data !== 4'd0) $display("FAIL reset_wr_data: got %0d expected 0", wr_data); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
        reset = 1'b0;
        step(1);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_single_point;
        int base;
        base = wa_q.size();
        wr_ack = 1'b1;
        push_point(5, 7, 3);
        step(3);
        checks++; if (wr_req !== 1'b0) $display("FAIL single_req_t3: got %b expected 0", wr_req); else passed++;
        step(1);
        checks++; if (wr_req !== 1'b1) $display("FAIL single_req_t4: got %b expected 1", wr_req); else passed++;
        checks++; if (wr_addr !== 19'd4485) $display("FAIL single_addr: got %0d expected 4485", wr_addr); else passed++;
        checks++; if (wr_data !== 4'd3) $display("FAIL single_data: got %0d expected 3", wr_data); else passed++;
        wait_not_busy(50);
        checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy); else passed++;
        checks++; if (wa_q.size() - base !== 1) $display("FAIL single_count: got %0d expected 1", wa_q.size() - base); else passed++;
    endtask

    task automatic test_line;
        int base;
        int exp_a[3];
        base = wa_q.size();
        exp_a = '{0, 641, 1282};
        wr_ack = 1'b1;
        push_point(0, 0, 1);
        push_point(1, 1, 2);
        push_point(2, 2, 3);
        wait_not_busy(100);
        checks++; if (wa_q.size() - base !== 3) $display("FAIL line_count: got %0d expected 3", wa_q.size() - base); else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (addr_at(base + k) !== exp_a[k] || data_at(base + k) !== k + 1)
                $display("FAIL line_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                         k, addr_at(base + k), data_at(base + k), exp_a[k], k + 1);
            else passed++;
        end
        checks++;
        if (cyc_at(base + 1) - cyc_at(base) !== 6)
            $display("FAIL line_spacing: got %0d cycles expected 6", cyc_at(base + 1) - cyc_at(base));
        else passed++;
    endtask

    task automatic test_offscreen;
        int base;
        int req0;
        base = wa_q.size();
        req0 = req_total;
        wr_ack = 1'b1;
        push_point(640, 10, 2);
        step(2);
        checks++; if (busy !== 1'b1) $display("FAIL offx_busy_next: got %b expected 1", busy); else passed++;
        step(1);
        checks++; if (busy !== 1'b0) $display("FAIL offx_busy_idle: got %b expected 0", busy); else passed++;
        push_point(10, 480, 2);
        step(2);
        checks++; if (busy !== 1'b1) $display("FAIL offy_busy_next: got %b expected 1", busy); else passed++;
        step(1);
        checks++; if (busy !== 1'b0) $display("FAIL offy_busy_idle: got %b expected 0", busy); else passed++;
        step(5);
        checks++; if (req_total - req0 !== 0) $display("FAIL off_no_req: got %0d req cycles expected 0", req_total - req0); else passed++;
        checks++; if (wa_q.size() - base !== 0) $display("FAIL off_no_write: got %0d writes expected 0", wa_q.size() - base); else passed++;
    endtask

    task automatic test_corners;
        int base;
        int exp_a[$];
        int exp_d[$];
        base = wa_q.size();
        wr_ack = 1'b1;
`ifdef PAINT_BRUSH_3X3_EN
        exp_a = '{0, 1, 640, 641, 306558, 306559, 307198, 307199};
        exp_d = '{5, 5, 5, 5, 15, 15, 15, 15};
        push_point(0, 0, 5);
        push_point(639, 479, 15);
`else
        exp_a = '{0, 307199, 639, 306560};
        exp_d = '{5, 15, 6, 9};
        push_point(0, 0, 5);
        push_point(639, 479, 15);
        push_point(639, 0, 6);
        push_point(0, 479, 9);
`endif
        wait_not_busy(400);
        checks++;
        if (wa_q.size() - base !== exp_a.size())
            $display("FAIL corner_count: got %0d expected %0d", wa_q.size() - base, exp_a.size());
        else passed++;
        foreach (exp_a[k]) begin
            checks++;
            if (addr_at(base + k) !== exp_a[k] || data_at(base + k) !== exp_d[k])
                $display("FAIL corner_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                         k, addr_at(base + k), data_at(base + k), exp_a[k], exp_d[k]);
            else passed++;
        end
    endtask

    task automatic test_overflow_stall;
        int base;
        int exp_a[9];
        int exp_d[9];
        base = wa_q.size();
        exp_a[0] = 641;
        exp_d[0] = 1;
        for (int i = 1; i < 9; i++) begin
            exp_a[i] = 12810 + (i - 1);
            exp_d[i] = i - 1;
        end
        wr_ack = 1'b0;
        // Park one point in WRITE so the whole burst has to sit in the FIFO.
        push_point(1, 1, 1);
        wait_req(20);
        checks++; if (wr_req !== 1'b1) $display("FAIL ovf_park_req: got %b expected 1", wr_req); else passed++;
        for (int i = 0; i < 9; i++) begin
            push_point(10 + i, 20, i);
            if (i == 7) begin
                checks++; if (overflow !== 1'b0) $display("FAIL ovf_after8: got %b expected 0", overflow); else passed++;
            end
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_after9: got %b expected 1", overflow); else passed++;
        for (int k = 0; k < 9; k++) begin
            wait_req(50);
            checks++; if (wr_req !== 1'b1) $display("FAIL ovf_req%0d: got %b expected 1", k, wr_req); else passed++;
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (wr_addr !== 19'(exp_a[k]) || wr_data !== 4'(exp_d[k]))
                    $display("FAIL ovf_stall%0d_%0d: got addr %0d data %0d expected addr %0d data %0d",
                             k, s, wr_addr, wr_data, exp_a[k], exp_d[k]);
                else passed++;
                step(1);
            end
            wr_ack = 1'b1;
            step(1);
            wr_ack = 1'b0;
        end
        wait_not_busy(50);
        checks++; if (wa_q.size() - base !== 9) $display("FAIL ovf_count: got %0d writes expected 9 (parked + 8)", wa_q.size() - base); else passed++;
        checks++; if (addr_at(base + 8) !== 12817) $display("FAIL ovf_last: got %0d expected 12817", addr_at(base + 8)); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ovf_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_transfer;
        int base;
        int req0;
        wr_ack = 1'b0;
        push_point(30, 0, 1);
        push_point(30, 1, 2);
        push_point(30, 2, 3);
        push_point(30, 3, 4);
        wait_req(20);
        checks++; if (wr_req !== 1'b1) $display("FAIL rst_mid_req_before: got %b expected 1", wr_req); else passed++;
        reset = 1'b1;
        step(1);
        base = wa_q.size();
        req0 = req_total;
        checks++; if (wr_req !== 1'b0) $display("FAIL rst_mid_req: got %b expected 0", wr_req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_mid_overflow: got %b expected 0", overflow); else passed++;
        reset = 1'b0;
        wr_ack = 1'b1;
        step(40);
        checks++; if (wa_q.size() - base !== 0) $display("FAIL rst_mid_writes: got %0d expected 0", wa_q.size() - base); else passed++;
        checks++; if (req_total - req0 !== 0) $display("FAIL rst_mid_req_cycles: got %0d expected 0", req_total - req0); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_point;
        test_line;
        test_offscreen;
        test_corners;
        test_overflow_stall;
        test_reset_mid_transfer;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
        $fatal(1);
    end

endmodule
